// File: rtl/sdram_p2_arbiter_if.sv
// sdram_p2_arbiter_if: client request bundle and port2 controller bundle of the port2 arbiter
interface sdram_p2_arbiter_if #(
  parameter int NUM_CLI = 3
);
  logic [NUM_CLI-1:0]    cli_req;
  logic [NUM_CLI-1:0]    cli_we;
  logic [NUM_CLI*8-1:0]  cli_burstcnt;
  logic [NUM_CLI*24-1:0] cli_a;
  logic [NUM_CLI*8-1:0]  cli_ds;
  logic [NUM_CLI*64-1:0] cli_d;
  logic [NUM_CLI-1:0]    cli_rvalid;
  logic [63:0]           cli_q;
  logic [NUM_CLI-1:0]    cli_done;
  logic                  port2_req;
  logic                  port2_we;
  logic [7:0]            port2_burstcnt;
  logic [23:0]           port2_a;
  logic [7:0]            port2_ds;
  logic [63:0]           port2_d;
  logic                  port2_busy;
  logic                  port2_ack;
  logic [63:0]           port2_q;
  modport slave (
    input  cli_req, cli_we, cli_burstcnt, cli_a, cli_ds, cli_d, port2_busy, port2_ack, port2_q,
    output cli_rvalid, cli_q, cli_done, port2_req, port2_we, port2_burstcnt, port2_a, port2_ds, port2_d
  );
  modport master (
    output cli_req, cli_we, cli_burstcnt, cli_a, cli_ds, cli_d, port2_busy, port2_ack, port2_q,
    input  cli_rvalid, cli_q, cli_done, port2_req, port2_we, port2_burstcnt, port2_a, port2_ds, port2_d
  );
endinterface

// File: rtl/sdram_p2_arbiter.sv
// sdram_p2_arbiter: round-robin arbiter serialising NUM_CLI clients onto the SDRAM port2 burst port
module sdram_p2_arbiter #(
  parameter int NUM_CLI = 3
) (
  input logic               clk,
  input logic               reset,
  sdram_p2_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_CLI);
  typedef enum logic [2:0] {IDLE, ISSUE, ACCEPT, RDATA, DONE} state_t;
  state_t             state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d, last_q, last_d, pick;
  logic               we_q, we_d, any_req, ack_ok;
  logic [23:0]        a_q, a_d;
  logic [7:0]         ds_q, ds_d, bc_q, bc_d, req_bc;
  logic [63:0]        d_q, d_d, q_q, q_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [NUM_CLI-1:0] rvalid_q, rvalid_d;

  assign req_bc = bus.cli_burstcnt[pick*8 +: 8];

  // nearest requester after the last served one wins, so the last owner ranks lowest
  always_comb begin
    pick = last_q;
    any_req = 1'b0;
    for (int i = NUM_CLI; i >= 1; i--) begin
      if (bus.cli_req[IW'((int'(last_q) + i) % NUM_CLI)]) begin
        pick = IW'((int'(last_q) + i) % NUM_CLI);
        any_req = 1'b1;
      end
    end
  end

  // transaction sequencing, command latching and read-word accounting
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    we_d = we_q;
    a_d = a_q;
    ds_d = ds_q;
    d_d = d_q;
    bc_d = bc_q;
    cnt_d = cnt_q;
    q_d = q_q;
    rvalid_d = '0;
    ack_ok = bus.port2_ack && !we_q && cnt_q != 9'd0 && (state_q == ACCEPT || state_q == RDATA);
    if (ack_ok) begin
      q_d = bus.port2_q;
      rvalid_d[owner_q] = 1'b1;
      cnt_d = cnt_q - 9'd1;
    end
    case (state_q)
      IDLE: if (any_req) begin
        state_d = ISSUE;
        owner_d = pick;
        last_d = pick;
        we_d = bus.cli_we[pick];
        a_d = bus.cli_a[pick*24 +: 24];
        ds_d = bus.cli_ds[pick*8 +: 8];
        d_d = bus.cli_d[pick*64 +: 64];
        bc_d = bus.cli_we[pick] ? 8'd1 : req_bc;
        cnt_d = bus.cli_we[pick] ? 9'd1 : (req_bc == 8'd0 ? 9'd256 : {1'b0, req_bc});
      end
      ISSUE: state_d = ACCEPT;
      ACCEPT: if (!bus.port2_busy) state_d = (we_q || cnt_q == 9'd0) ? DONE : RDATA;
      RDATA: if (cnt_q == 9'd0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q <= IW'(NUM_CLI - 1);
      we_q <= 1'b0;
      a_q <= '0;
      ds_q <= '0;
      d_q <= '0;
      bc_q <= '0;
      cnt_q <= '0;
      q_q <= '0;
      rvalid_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      we_q <= we_d;
      a_q <= a_d;
      ds_q <= ds_d;
      d_q <= d_d;
      bc_q <= bc_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.port2_req = state_q == ISSUE;
  assign bus.port2_we = we_q;
  assign bus.port2_burstcnt = bc_q;
  assign bus.port2_a = a_q;
  assign bus.port2_ds = ds_q;
  assign bus.port2_d = d_q;
  assign bus.cli_rvalid = rvalid_q;
  assign bus.cli_q = q_q;
  assign bus.cli_done = (state_q == DONE) ? NUM_CLI'(1) << owner_q : '0;
endmodule

// File: tb/tb_sdram_p2_arbiter.sv
// tb_sdram_p2_arbiter: directed bench with a port2 controller model and rvalid/done scoreboards
module tb_sdram_p2_arbiter;
  localparam int N = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hold = 1'b0;
  always #5 clk = ~clk;

  sdram_p2_arbiter_if #(.NUM_CLI(N)) bus();
  sdram_p2_arbiter #(.NUM_CLI(N)) dut (.clk(clk), .reset(reset), .bus(bus));
  assign bus.port2_busy = bus.port2_req | hold;

  typedef struct {int owner; logic we; logic [23:0] a; logic [7:0] bc; logic [7:0] ds; logic [63:0] d;} cmd_t;
  typedef struct {int owner; logic [63:0] data;} rv_t;
  cmd_t exp_cmd[$];
  rv_t  exp_rv[$];
  int   exp_done[$];
  int checks = 0, failures = 0, ndone = 0, lat = 0, gap = 0, ack_limit = 1000;
  int nrv[N];
  bit sticky = 1'b0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wdata(logic [23:0] a, int i);
    return {8'h00, a, 32'(i + 1) * 32'h11};
  endfunction

  function automatic int rv_total();
    return nrv[0] + nrv[1] + nrv[2];
  endfunction

  task automatic set_fields(int c, logic we, logic [23:0] a, logic [7:0] bc, logic [7:0] ds, logic [63:0] d);
    bus.cli_we[c] = we;
    bus.cli_a[c*24 +: 24] = a;
    bus.cli_burstcnt[c*8 +: 8] = bc;
    bus.cli_ds[c*8 +: 8] = ds;
    bus.cli_d[c*64 +: 64] = d;
  endtask

  task automatic expect_cmd(int c, logic we, logic [23:0] a, logic [7:0] bc, logic [7:0] ds, logic [63:0] d);
    exp_cmd.push_back(cmd_t'{c, we, a, bc, ds, d});
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(int target, int budget, string tag);
    int k = 0;
    while (ndone < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, ndone, target);
  endtask

  task automatic wait_rv(int c, int target, int budget, string tag);
    int k = 0;
    while (nrv[c] < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, nrv[c], target);
  endtask

  task automatic check_zero(string p);
    chk({p, "_req"}, bus.port2_req, 0);
    chk({p, "_we"}, bus.port2_we, 0);
    chk({p, "_bc"}, bus.port2_burstcnt, 0);
    chk({p, "_a"}, bus.port2_a, 0);
    chk({p, "_ds"}, bus.port2_ds, 0);
    chk({p, "_d"}, bus.port2_d, 0);
    chk({p, "_rvalid"}, bus.cli_rvalid, 0);
    chk({p, "_q"}, bus.cli_q, 0);
    chk({p, "_done"}, bus.cli_done, 0);
  endtask

  // controller model: checks each issued command, then returns busy and read words
  initial begin
    cmd_t c;
    int words;
    forever begin
      @(negedge clk);
      if (!reset && bus.port2_req) begin
        if (exp_cmd.size() == 0) chk("cmd_unexp", bus.port2_req, 0);
        else begin
          c = exp_cmd.pop_front();
          chk("cmd_a", bus.port2_a, c.a);
          chk("cmd_we", bus.port2_we, c.we);
          chk("cmd_bc", bus.port2_burstcnt, c.we ? 8'd1 : c.bc);
          if (c.we) begin
            chk("cmd_ds", bus.port2_ds, c.ds);
            chk("cmd_d", bus.port2_d, c.d);
          end
          words = c.we ? 0 : (c.bc == 8'd0 ? 256 : int'(c.bc));
          for (int k = 0; k < lat; k++) begin
            @(posedge clk);
            #1 hold = 1'b1;
          end
          @(posedge clk);
          #1 hold = 1'b0;
          if (c.we) exp_done.push_back(c.owner);
          else begin
            for (int i = 0; i < words && i < ack_limit; i++) begin
              bus.port2_ack = 1'b1;
              bus.port2_q = wdata(c.a, i);
              exp_rv.push_back(rv_t'{c.owner, wdata(c.a, i)});
              @(posedge clk);
              #1 bus.port2_ack = 1'b0;
              repeat (gap) begin
                @(posedge clk);
                #1;
              end
            end
            if (words <= ack_limit) exp_done.push_back(c.owner);
          end
        end
      end
    end
  end

  // output monitor: rvalid and done pulses are popped against expectations
  initial begin
    rv_t e;
    int o;
    forever begin
      @(negedge clk);
      if (!reset && bus.cli_rvalid != '0) begin
        if (exp_rv.size() == 0) chk("rv_unexp", bus.cli_rvalid, 0);
        else begin
          e = exp_rv.pop_front();
          chk("rv_owner", bus.cli_rvalid, N'(1) << e.owner);
          chk("rv_data", bus.cli_q, e.data);
          nrv[e.owner]++;
        end
      end
      if (!reset && bus.cli_done != '0) begin
        if (exp_done.size() == 0) chk("done_unexp", bus.cli_done, 0);
        else begin
          o = exp_done.pop_front();
          chk("done_owner", bus.cli_done, N'(1) << o);
          chk("done_words_left", exp_rv.size(), 0);
          if (!sticky) bus.cli_req[o] = 1'b0;
        end
        ndone++;
      end
    end
  end

  initial begin
    int b0, b1, b2, tot;
    bus.cli_req = '0;
    bus.cli_we = '0;
    bus.cli_burstcnt = '0;
    bus.cli_a = '0;
    bus.cli_ds = '0;
    bus.cli_d = '0;
    bus.port2_ack = 1'b0;
    bus.port2_q = '0;
    foreach (nrv[i]) nrv[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    @(posedge clk);
    #1 reset = 1'b0;

    sticky = 1'b1;
    for (int c = 0; c < N; c++) set_fields(c, 1'b0, 24'h001000 * 24'(c + 1), 8'd1, 8'h00, 64'h0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++) expect_cmd(c, 1'b0, 24'h001000 * 24'(c + 1), 8'd1, 8'h00, 64'h0);
    bus.cli_req = '1;
    wait_done(6, 200, "rr_done");
    bus.cli_req = '0;
    sticky = 1'b0;
    chk("rr_order_consumed", exp_cmd.size(), 0);
    chk("rr_words", rv_total(), 6);
    cyc(3);

    b1 = nrv[1];
    set_fields(1, 1'b0, 24'h000000, 8'd4, 8'h00, 64'h0);
    expect_cmd(1, 1'b0, 24'h000000, 8'd4, 8'h00, 64'h0);
    bus.cli_req[1] = 1'b1;
    wait_done(7, 100, "rd4_done");
    chk("rd4_words", nrv[1] - b1, 4);
    cyc(2);

    tot = rv_total();
    lat = 2;
    set_fields(0, 1'b1, 24'h000100, 8'd7, 8'hFF, 64'hDEAD_BEEF_0123_4567);
    expect_cmd(0, 1'b1, 24'h000100, 8'd7, 8'hFF, 64'hDEAD_BEEF_0123_4567);
    bus.cli_req[0] = 1'b1;
    wait_done(8, 100, "wr_done");
    lat = 0;
    chk("wr_no_rvalid", rv_total(), tot);
    cyc(2);

    b2 = nrv[2];
    set_fields(2, 1'b0, 24'h200000, 8'd0, 8'h00, 64'h0);
    expect_cmd(2, 1'b0, 24'h200000, 8'd0, 8'h00, 64'h0);
    bus.cli_req[2] = 1'b1;
    wait_done(9, 600, "rd256_done");
    chk("rd256_words", nrv[2] - b2, 256);
    cyc(2);

    tot = rv_total();
    bus.port2_ack = 1'b1;
    bus.port2_q = '1;
    cyc(1);
    bus.port2_ack = 1'b0;
    cyc(3);
    chk("spur_no_rvalid", rv_total(), tot);
    chk("spur_no_req", bus.port2_req, 0);

    b0 = nrv[0];
    b1 = nrv[1];
    b2 = nrv[2];
    gap = 1;
    set_fields(1, 1'b0, 24'h300000, 8'd8, 8'h00, 64'h0);
    expect_cmd(1, 1'b0, 24'h300000, 8'd8, 8'h00, 64'h0);
    bus.cli_req[1] = 1'b1;
    wait_rv(1, b1 + 2, 100, "tog_first_words");
    bus.cli_req[0] = 1'b1;
    bus.cli_req[2] = 1'b1;
    repeat (2) @(negedge clk);
    bus.cli_req[0] = 1'b0;
    @(negedge clk);
    bus.cli_req[2] = 1'b0;
    wait_done(10, 100, "tog_done");
    gap = 0;
    chk("tog_owner_words", nrv[1] - b1, 8);
    chk("tog_others_words", nrv[0] + nrv[2], b0 + b2);
    chk("tog_no_extra_cmd", exp_cmd.size(), 0);
    cyc(2);

    b0 = nrv[0];
    ack_limit = 2;
    set_fields(0, 1'b0, 24'h400000, 8'd8, 8'h00, 64'h0);
    expect_cmd(0, 1'b0, 24'h400000, 8'd8, 8'h00, 64'h0);
    bus.cli_req[0] = 1'b1;
    wait_rv(0, b0 + 2, 100, "abort_two_words");
    @(posedge clk);
    #1 reset = 1'b1;
    bus.cli_req = '0;
    @(negedge clk);
    check_zero("abort");
    cyc(2);
    ack_limit = 1000;
    reset = 1'b0;
    cyc(1);

    b1 = nrv[1];
    set_fields(1, 1'b0, 24'h500000, 8'd2, 8'h00, 64'h0);
    expect_cmd(1, 1'b0, 24'h500000, 8'd2, 8'h00, 64'h0);
    bus.cli_req[1] = 1'b1;
    wait_done(11, 100, "restart_done");
    chk("restart_words", nrv[1] - b1, 2);
    chk("restart_abort_words", nrv[0] - b0, 2);
    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
